// File: rtl/mb_recon_engine_if.sv
// Bus bundle for the reconstruction engine: picture config, residual input,
// prediction RAM port and pixel/status outputs.
interface mb_recon_engine_if #(
    parameter int RES_W      = 9,
    parameter int PIX_W      = 8,
    parameter int MB_COL_W   = 6,
    parameter int MB_ROW_W   = 5,
    parameter int PRED_OFS_W = 10
);
    logic                  Start_I;
    logic [1:0]            Chroma_Format_I;
    logic [MB_COL_W-1:0]   Mb_Cols_I;
    logic [MB_ROW_W-1:0]   Mb_Rows_I;
    logic                  Intra_I;
    logic                  Residual_Valid_I;
    logic [RES_W-1:0]      Residual_Data_I;
    logic [PRED_OFS_W:0]   Pred_Addr_O;
    logic [PIX_W-1:0]      Pred_Data_I;
    logic [PIX_W-1:0]      Pix_Data_O;
    logic                  Pix_Valid_O;
    logic [MB_COL_W-1:0]   Mb_Col_O;
    logic [MB_ROW_W-1:0]   Mb_Row_O;
    logic                  Bank_Done_O;
    logic                  Pic_Done_O;
    logic                  Busy_O;
    logic                  Overrun_O;

    modport slave (
        input  Start_I, Chroma_Format_I, Mb_Cols_I, Mb_Rows_I, Intra_I,
               Residual_Valid_I, Residual_Data_I, Pred_Data_I,
        output Pred_Addr_O, Pix_Data_O, Pix_Valid_O, Mb_Col_O, Mb_Row_O,
               Bank_Done_O, Pic_Done_O, Busy_O, Overrun_O
    );

    modport master (
        output Start_I, Chroma_Format_I, Mb_Cols_I, Mb_Rows_I, Intra_I,
               Residual_Valid_I, Residual_Data_I, Pred_Data_I,
        input  Pred_Addr_O, Pix_Data_O, Pix_Valid_O, Mb_Col_O, Mb_Row_O,
               Bank_Done_O, Pic_Done_O, Busy_O, Overrun_O
    );
endinterface

// File: rtl/mb_recon_engine.sv
// Reconstruction back-end: residual + prediction, clip to pixel range, with
// sample/block/macroblock tracking and ping-pong prediction addressing.
module mb_recon_engine #(
    parameter int RES_W      = 9,
    parameter int PIX_W      = 8,
    parameter int MB_COL_W   = 6,
    parameter int MB_ROW_W   = 5,
    parameter int PRED_OFS_W = 10
) (
    input  logic              clock,
    input  logic              resetn,
    mb_recon_engine_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    localparam logic signed [RES_W:0] PIX_MAX = (RES_W+1)'((1 << PIX_W) - 1);

    state_t state_q, state_d;
    logic [3:0]          bpm_m1_q;
    logic [MB_COL_W-1:0] cols_m1_q, col_q, col_d;
    logic [MB_ROW_W-1:0] rows_m1_q, row_q, row_d;
    logic [5:0]          sample_q, sample_d;
    logic [3:0]          block_q, block_d;
    logic                bank_q, bank_d;
    logic                intra_q, intra_d;
    logic                flush_q, overrun_q;
    logic                s0_valid_q, s0_intra_q, s0_last_q;
    logic [RES_W-1:0]    s0_res_q;
    logic                pix_valid_q, pic_done_q, bank_done_q;
    logic [PIX_W-1:0]    pix_q;

    logic accept, last_sample, last_blk, last_mb, last_col, last_row, last_pic, intra_cur;
    logic [PIX_W-1:0]      pred_eff, clip_val;
    logic signed [RES_W:0] sum;

    // A sample arriving together with Start_I belongs to no picture and is dropped.
    assign accept      = bus.Residual_Valid_I && (state_q == S_RUN) && !bus.Start_I;
    assign last_sample = (sample_q == 6'd63);
    assign last_blk    = (block_q == bpm_m1_q);
    assign last_mb     = last_sample && last_blk;
    assign last_col    = (col_q == cols_m1_q);
    assign last_row    = (row_q == rows_m1_q);
    assign last_pic    = last_mb && last_col && last_row;
    assign intra_cur   = (sample_q == 6'd0 && block_q == 4'd0) ? bus.Intra_I : intra_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (accept && last_pic) state_d = S_FLUSH;
            S_FLUSH: if (flush_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.Start_I) state_d = S_RUN;
    end

    always_comb begin
        sample_d = sample_q;
        block_d  = block_q;
        col_d    = col_q;
        row_d    = row_q;
        bank_d   = bank_q;
        intra_d  = intra_q;
        if (accept) begin
            sample_d = sample_q + 6'd1;
            if (sample_q == 6'd0 && block_q == 4'd0) intra_d = bus.Intra_I;
            if (last_sample) begin
                block_d = last_blk ? 4'd0 : block_q + 4'd1;
                if (last_blk) begin
                    bank_d = ~bank_q;
                    col_d  = last_col ? '0 : col_q + MB_COL_W'(1);
                    if (last_col) row_d = last_row ? '0 : row_q + MB_ROW_W'(1);
                end
            end
        end
        if (bus.Start_I) begin
            sample_d = '0;
            block_d  = '0;
            col_d    = '0;
            row_d    = '0;
            bank_d   = 1'b0;
            intra_d  = 1'b0;
        end
    end

    // Sum is one bit wider than the residual so pred + positive residual cannot wrap.
    always_comb begin
        pred_eff = s0_intra_q ? '0 : bus.Pred_Data_I;
        sum = $signed({s0_res_q[RES_W-1], s0_res_q})
            + $signed({{(RES_W+1-PIX_W){1'b0}}, pred_eff});
        if (sum[RES_W])          clip_val = '0;
        else if (sum > PIX_MAX)  clip_val = '1;
        else                     clip_val = sum[PIX_W-1:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            bpm_m1_q    <= 4'd5;
            cols_m1_q   <= '0;
            rows_m1_q   <= '0;
            sample_q    <= '0;
            block_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= 1'b0;
            intra_q     <= 1'b0;
            flush_q     <= 1'b0;
            overrun_q   <= 1'b0;
            s0_valid_q  <= 1'b0;
            s0_intra_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_res_q    <= '0;
            pix_valid_q <= 1'b0;
            pic_done_q  <= 1'b0;
            bank_done_q <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            block_q  <= block_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bank_q   <= bank_d;
            intra_q  <= intra_d;
            flush_q  <= (state_q == S_FLUSH) && !flush_q && !bus.Start_I;

            s0_res_q   <= bus.Residual_Data_I;
            s0_intra_q <= intra_cur;
            pix_q      <= clip_val;
            if (bus.Start_I) begin
                case (bus.Chroma_Format_I)
                    2'd2:    bpm_m1_q <= 4'd7;
                    2'd3:    bpm_m1_q <= 4'd11;
                    default: bpm_m1_q <= 4'd5;
                endcase
                cols_m1_q   <= (bus.Mb_Cols_I == '0) ? '0 : bus.Mb_Cols_I - MB_COL_W'(1);
                rows_m1_q   <= (bus.Mb_Rows_I == '0) ? '0 : bus.Mb_Rows_I - MB_ROW_W'(1);
                overrun_q   <= 1'b0;
                s0_valid_q  <= 1'b0;
                s0_last_q   <= 1'b0;
                pix_valid_q <= 1'b0;
                pic_done_q  <= 1'b0;
                bank_done_q <= 1'b0;
            end else begin
                if (bus.Residual_Valid_I && state_q != S_RUN) overrun_q <= 1'b1;
                s0_valid_q  <= accept;
                s0_last_q   <= accept && last_pic;
                pix_valid_q <= s0_valid_q;
                pic_done_q  <= s0_valid_q && s0_last_q;
                bank_done_q <= accept && last_mb;
            end
        end
    end

    assign bus.Pred_Addr_O = {bank_q, PRED_OFS_W'({block_q, sample_q})};
    assign bus.Pix_Data_O  = pix_q;
    assign bus.Pix_Valid_O = pix_valid_q;
    assign bus.Mb_Col_O    = col_q;
    assign bus.Mb_Row_O    = row_q;
    assign bus.Bank_Done_O = bank_done_q;
    assign bus.Pic_Done_O  = pic_done_q;
    assign bus.Busy_O      = (state_q != S_IDLE);
    assign bus.Overrun_O   = overrun_q;
endmodule

// File: tb/tb_mb_recon_engine.sv
// Directed bench for mb_recon_engine: whole pictures in several formats, clipping,
// gapped input, overrun, restart and mid-picture reset.
module tb_mb_recon_engine;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mb_recon_engine_if bus ();
    mb_recon_engine dut (.clock(clk), .resetn(rstn), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Expected-output history: index 0 = this cycle's input, 2 = two cycles ago.
    logic       hv[3];
    logic [7:0] hd[3];
    logic       hl[3];
    logic       hb[3];

    // Non-intra, prediction 250: residual and hand-computed clipped pixel.
    int rtab[8] = '{10, -256, -250, 5, -10, -251, 255, -249};
    int etab[8] = '{255, 0, 0, 255, 240, 0, 255, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0; hd[k] = 8'd0; hl[k] = 1'b0; hb[k] = 1'b0;
        end
    endtask

    task automatic shift_hist(input logic ev, input logic [7:0] ed, input logic emb, input logic epic);
        for (int k = 2; k > 0; k--) begin
            hv[k] = hv[k-1]; hd[k] = hd[k-1]; hl[k] = hl[k-1]; hb[k] = hb[k-1];
        end
        hv[0] = ev; hd[0] = ed; hl[0] = epic; hb[0] = emb;
    endtask

    task automatic check_outs();
        chk("pix_valid", 32'(bus.Pix_Valid_O), 32'(hv[2]));
        if (hv[2]) chk("pix_data", 32'(bus.Pix_Data_O), 32'(hd[2]));
        chk("pic_done", 32'(bus.Pic_Done_O), 32'(hl[2]));
        chk("bank_done", 32'(bus.Bank_Done_O), 32'(hb[1]));
    endtask

    task automatic step(input logic v, input logic signed [8:0] r, input logic intr,
                        input logic ev, input logic [7:0] ed, input logic emb, input logic epic,
                        input logic cpos, input logic [10:0] eaddr,
                        input logic [5:0] ecol, input logic [4:0] erow);
        @(posedge clk); #1;
        bus.Start_I          = 1'b0;
        bus.Residual_Valid_I = v;
        bus.Residual_Data_I  = r;
        bus.Intra_I          = intr;
        shift_hist(ev, ed, emb, epic);
        @(negedge clk);
        check_outs();
        if (cpos) begin
            chk("pred_addr", 32'(bus.Pred_Addr_O), 32'(eaddr));
            chk("mb_col", 32'(bus.Mb_Col_O), 32'(ecol));
            chk("mb_row", 32'(bus.Mb_Row_O), 32'(erow));
            chk("busy_run", 32'(bus.Busy_O), 32'd1);
        end
    endtask

    task automatic idle();
        step(1'b0, 9'sd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 11'd0, 6'd0, 5'd0);
    endtask

    // Start cycle: outputs still show older pipeline contents, afterwards all is flushed.
    task automatic start_pic(input logic [1:0] fmt, input logic [5:0] cols,
                             input logic [4:0] rows, input logic v);
        @(posedge clk); #1;
        bus.Start_I          = 1'b1;
        bus.Chroma_Format_I  = fmt;
        bus.Mb_Cols_I        = cols;
        bus.Mb_Rows_I        = rows;
        bus.Residual_Valid_I = v;
        bus.Residual_Data_I  = 9'sd7;
        shift_hist(1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs();
        clear_hist();
    endtask

    // intra_mode: 0 none, 1 all, 2 odd macroblocks. Intra_I is inverted off sample 0
    // of block 0 to prove it is held for the macroblock.
    task automatic run_pic(input int fmt, input int ncols, input int nrows, input int gap,
                           input int intra_mode, input int mode, input int pred, input int stop);
        int bpm, nmb, i, res, e;
        logic im;
        bpm = (fmt == 2) ? 8 : (fmt == 3) ? 12 : 6;
        nmb = ncols * nrows;
        bus.Pred_Data_I = 8'(pred);
        i = 0;
        for (int mb = 0; mb < nmb; mb++) begin
            for (int b = 0; b < bpm; b++) begin
                for (int s = 0; s < 64; s++) begin
                    if (i == stop) return;
                    if (i > 0) repeat (gap - 1) idle();
                    im = (intra_mode == 2) ? mb[0] : intra_mode[0];
                    if (mode == 0) begin
                        res = 5; e = 5;
                    end else if (mode == 1) begin
                        res = rtab[i % 8]; e = etab[i % 8];
                    end else begin
                        res = ((i * 37) % 201) - 100;
                        e = im ? ((res < 0) ? 0 : res) : res + pred;
                    end
                    step(1'b1, 9'(res), (b == 0 && s == 0) ? im : ~im, 1'b1, 8'(e),
                         (b == bpm - 1 && s == 63),
                         (mb == nmb - 1 && b == bpm - 1 && s == 63),
                         1'b1, {mb[0], 10'(b * 64 + s)}, 6'(mb % ncols), 5'(mb / ncols));
                    i++;
                end
            end
        end
        repeat (3) idle();
        chk("busy_end", 32'(bus.Busy_O), 32'd0);
    endtask

    initial begin
        bus.Start_I = 1'b0; bus.Chroma_Format_I = 2'd0; bus.Mb_Cols_I = '0; bus.Mb_Rows_I = '0;
        bus.Intra_I = 1'b0; bus.Residual_Valid_I = 1'b0; bus.Residual_Data_I = '0;
        bus.Pred_Data_I = '0;
        clear_hist();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_valid", 32'(bus.Pix_Valid_O), 32'd0);
        chk("rst_pix_data", 32'(bus.Pix_Data_O), 32'd0);
        chk("rst_busy", 32'(bus.Busy_O), 32'd0);
        chk("rst_addr", 32'(bus.Pred_Addr_O), 32'd0);
        chk("rst_col", 32'(bus.Mb_Col_O), 32'd0);
        chk("rst_row", 32'(bus.Mb_Row_O), 32'd0);
        chk("rst_overrun", 32'(bus.Overrun_O), 32'd0);
        chk("rst_pic_done", 32'(bus.Pic_Done_O), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1: 4:2:0, cols=0 behaves as 1, intra, residual 5, prediction must be ignored
        start_pic(2'd1, 6'd0, 5'd1, 1'b0);
        run_pic(1, 1, 1, 1, 1, 0, 77, -1);

        // 2: clipping against prediction 250
        start_pic(2'd1, 6'd1, 5'd1, 1'b0);
        run_pic(1, 1, 1, 1, 0, 1, 250, -1);

        // 3: 4:4:4, 2x2 macroblocks, intra on odd macroblocks
        start_pic(2'd3, 6'd2, 5'd2, 1'b0);
        run_pic(3, 2, 2, 1, 2, 2, 120, -1);

        // 4: 4:2:2, rows=0 behaves as 1, one sample every third cycle
        start_pic(2'd2, 6'd1, 5'd0, 1'b0);
        run_pic(2, 1, 1, 3, 0, 2, 120, -1);

        // 5: samples while idle are dropped and flagged
        step(1'b1, 9'sd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 11'd0, 6'd0, 5'd0);
        step(1'b1, 9'sd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 11'd0, 6'd0, 5'd0);
        idle();
        idle();
        chk("overrun_set", 32'(bus.Overrun_O), 32'd1);
        chk("overrun_busy", 32'(bus.Busy_O), 32'd0);
        start_pic(2'd1, 6'd1, 5'd1, 1'b0);
        idle();
        chk("overrun_clr", 32'(bus.Overrun_O), 32'd0);

        // 6a: restart at sample 100 with a sample in the Start_I cycle; format 0 acts as 4:2:0
        run_pic(1, 1, 1, 1, 0, 2, 120, 100);
        start_pic(2'd0, 6'd1, 5'd1, 1'b1);
        idle();
        chk("start_drop_overrun", 32'(bus.Overrun_O), 32'd0);
        run_pic(1, 1, 1, 1, 0, 2, 120, -1);

        // 6b: reset inside the second macroblock (bank 1, col 1), then a normal picture
        start_pic(2'd1, 6'd2, 5'd1, 1'b0);
        run_pic(1, 2, 1, 1, 0, 2, 120, 500);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_pix_valid", 32'(bus.Pix_Valid_O), 32'd0);
        chk("arst_busy", 32'(bus.Busy_O), 32'd0);
        chk("arst_addr", 32'(bus.Pred_Addr_O), 32'd0);
        chk("arst_col", 32'(bus.Mb_Col_O), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.Residual_Valid_I = 1'b0;
        clear_hist();
        idle();
        start_pic(2'd1, 6'd2, 5'd1, 1'b0);
        run_pic(1, 2, 1, 1, 2, 2, 120, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
